// File: rtl/conv_sched_pkg.sv
// Shared types and defaults for the conv filter scheduler.
//   state_e         : scheduler phases (idle, issuing taps, waiting for results, done pulse)
//   NUM_FILTERS_DEF : default filters per output pixel
package conv_sched_pkg;

    localparam int unsigned NUM_FILTERS_DEF = 9;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/filter_idx_counter.sv
// Modulo-NUM_FILTERS filter index counter.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   en         : advance the index by one
//   clr        : synchronous clear to 0 (wins over en)
//   idx        : current filter index
//   wrap       : en while idx is at NUM_FILTERS-1 (index returns to 0 next cycle)
module filter_idx_counter
    import conv_sched_pkg::*;
#(
    parameter int unsigned NUM_FILTERS = NUM_FILTERS_DEF,
    parameter int unsigned IDX_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [IDX_W-1:0] idx,
    output logic             wrap
);

    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NUM_FILTERS - 1);

    logic [IDX_W-1:0] idx_q, idx_d;

    assign wrap = en && (idx_q == IdxLast);
    assign idx  = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (wrap) begin
            idx_d = '0;
        end else if (en) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/conv_filter_scheduler.sv
// Sequences the conv filter datapath over a tile of output pixels: for every pixel it issues
// one tap per filter index with valid/ready, then waits for all per-pixel results and pulses
// done.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   start, num_pixels   : tile start request (accepted only when idle) and its pixel count
//   abort               : synchronous cancel, returns to idle without a done pulse
//   tap_valid/tap_ready : tap handshake for (filt_idx, pix_idx)
//   acc_clear, acc_last : first / last filter of a pixel, qualified by tap_valid
//   res_valid           : one pixel result completed by the datapath
//   busy, done          : tile in progress / one-cycle completion pulse
//   perf_stall_cnt      : RUN cycles with a stalled tap (only with PERF_COUNT_EN defined)
// Optional feature macro: PERF_COUNT_EN.
module conv_filter_scheduler
    import conv_sched_pkg::*;
#(
    parameter int unsigned NUM_FILTERS = NUM_FILTERS_DEF,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned PIX_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PIX_W-1:0] num_pixels,
    output logic             tap_valid,
    input  logic             tap_ready,
    output logic [IDX_W-1:0] filt_idx,
    output logic [PIX_W-1:0] pix_idx,
    output logic             acc_clear,
    output logic             acc_last,
    input  logic             res_valid,
    output logic             busy,
`ifdef PERF_COUNT_EN
    output logic [31:0]      perf_stall_cnt,
`endif
    output logic             done
);

    localparam logic [IDX_W-1:0] FiltLast = IDX_W'(NUM_FILTERS - 1);

    state_e           state_q, state_d;
    logic [PIX_W-1:0] num_pix_q, pix_idx_q;
    logic [PIX_W:0]   res_cnt_q, res_cnt_d;
    logic             tap_valid_q, tap_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             start_acc, step_en, filt_wrap, last_pix, final_xfer;
    logic             active, res_inc, res_reached;
    logic [IDX_W-1:0] filt_idx_w;

    assign start_acc  = (state_q == StIdle) && start && !abort;
    // tap_valid_q is only ever set in RUN, so this is the RUN-state transfer.
    assign step_en    = tap_valid_q && tap_ready && !abort;
    assign last_pix   = (pix_idx_q == (num_pix_q - PIX_W'(1)));
    assign final_xfer = filt_wrap && last_pix;

    assign active      = (state_q == StRun) || (state_q == StDrain);
    assign res_inc     = active && res_valid && (res_cnt_q < {1'b0, num_pix_q});
    assign res_cnt_d   = res_cnt_q + {{PIX_W{1'b0}}, res_inc};
    // Includes this cycle's res_valid so DRAIN leaves as soon as the last result lands.
    assign res_reached = (res_cnt_d >= {1'b0, num_pix_q});

    filter_idx_counter #(
        .NUM_FILTERS (NUM_FILTERS),
        .IDX_W       (IDX_W)
    ) u_filt_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (step_en),
        .clr   (abort || start_acc),
        .idx   (filt_idx_w),
        .wrap  (filt_wrap)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            tap_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_valid_q <= tap_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_pixels != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (final_xfer) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (res_reached) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        tap_valid_d = (state_d == StRun);
        busy_d      = (state_d == StRun) || (state_d == StDrain);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_pix_q <= '0;
            pix_idx_q <= '0;
            res_cnt_q <= '0;
        end else if (abort) begin
            pix_idx_q <= '0;
            res_cnt_q <= '0;
        end else if (start_acc) begin
            num_pix_q <= num_pixels;
            pix_idx_q <= '0;
            res_cnt_q <= '0;
        end else begin
            // Return to pixel 0 after the final tap so the idle outputs read (0, 0).
            if (filt_wrap) begin
                pix_idx_q <= last_pix ? '0 : pix_idx_q + PIX_W'(1);
            end
            res_cnt_q <= res_cnt_d;
        end
    end

`ifdef PERF_COUNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (start_acc) begin
            stall_cnt_q <= '0;
        end else if ((state_q == StRun) && tap_valid_q && !tap_ready) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

    assign tap_valid = tap_valid_q;
    assign filt_idx  = filt_idx_w;
    assign pix_idx   = pix_idx_q;
    assign acc_clear = tap_valid_q && (filt_idx_w == '0);
    assign acc_last  = tap_valid_q && (filt_idx_w == FiltLast);
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Scoreboard bench for conv_filter_scheduler: starting a tile pushes its expected tap stream,
// a monitor pops and compares on every transfer and predicts busy/tap_valid/done timing.
module tb_conv_filter_scheduler;

    localparam int NF = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_pixels = '0;
    logic        tap_ready = 1'b0;
    logic        res_valid = 1'b0;
    logic        tap_valid, acc_clear, acc_last, busy, done;
    logic [3:0]  filt_idx;
    logic [15:0] pix_idx;
`ifdef PERF_COUNT_EN
    logic [31:0] perf_stall_cnt;
`endif

    conv_filter_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .num_pixels (num_pixels),
        .tap_valid  (tap_valid),
        .tap_ready  (tap_ready),
        .filt_idx   (filt_idx),
        .pix_idx    (pix_idx),
        .acc_clear  (acc_clear),
        .acc_last   (acc_last),
        .res_valid  (res_valid),
        .busy       (busy),
`ifdef PERF_COUNT_EN
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .done       (done)
    );

    typedef struct {
        int f;
        int p;
    } tap_t;

    tap_t tap_q[$];
    int   res_q[$];
    int   last_res = 0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model of the tile in flight.
    bit model_on = 1'b0;
    int exp_n, res_seen, t_fin, r_fin, exp_done, acc_cyc, exp_stall;
    int ready_mode = 0;
    int stall_left = 0;
    int res_delay = 2;
    bit spur = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        model_on = 1'b0;
        tap_q.delete();
        res_q.delete();
        last_res = 0;
    endtask

    // Tap-ready generator.
    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0: tap_ready = 1'b1;
            1: tap_ready = !tap_ready;
            2: tap_ready = ($urandom_range(0, 3) != 0);
            3: begin
                if (stall_left > 0 && model_on && cyc >= acc_cyc && tap_q.size() > 0) begin
                    tap_ready = 1'b0;
                    stall_left--;
                end else begin
                    tap_ready = 1'b1;
                end
            end
            default: tap_ready = 1'b1;
        endcase
    end

    // Datapath stand-in: one res_valid per pixel at the scheduled cycle.
    initial forever begin
        @(posedge clk);
        #2;
        if (res_q.size() > 0 && res_q[0] <= cyc) begin
            void'(res_q.pop_front());
            res_valid = 1'b1;
        end else begin
            res_valid = spur;
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        tap_t e;
        bit   in_run, exp_busy, exp_dn;
        int   t;
        forever begin
            @(negedge clk);
            in_run   = model_on && (cyc >= acc_cyc) && (tap_q.size() > 0);
            exp_busy = model_on && (cyc >= acc_cyc) && !(exp_done >= 0 && cyc >= exp_done);
            check("tap_valid", tap_valid, in_run);
            check("busy", busy, exp_busy);
            if (in_run && !tap_ready) exp_stall++;
            if (model_on && tap_valid && tap_ready && tap_q.size() > 0) begin
                e = tap_q.pop_front();
                check("filt_idx", filt_idx, e.f);
                check("pix_idx", pix_idx, e.p);
                check("acc_clear", acc_clear, e.f == 0);
                check("acc_last", acc_last, e.f == NF - 1);
                if (e.f == NF - 1) begin
                    t = cyc + 1 + ((res_delay >= 0) ? res_delay : int'($urandom_range(0, 5)));
                    if (t <= last_res) t = last_res + 1;
                    last_res = t;
                    res_q.push_back(t);
                end
                if (tap_q.size() == 0) t_fin = cyc + 1;
            end
            if (model_on && cyc >= acc_cyc && res_valid && res_seen < exp_n) begin
                res_seen++;
                if (res_seen == exp_n) r_fin = cyc + 1;
            end
            if (model_on && exp_done < 0 && t_fin >= 0 && r_fin >= 0) begin
                exp_done = (t_fin + 1 > r_fin) ? t_fin + 1 : r_fin;
            end
            exp_dn = model_on && exp_done >= 0 && cyc == exp_done;
            check("done", done, exp_dn);
            if (exp_dn) begin
`ifdef PERF_COUNT_EN
                check("perf_stall_cnt", perf_stall_cnt, exp_stall);
`endif
                model_on = 1'b0;
            end
        end
    end

    task automatic start_tile(input int n, input int rmode);
        ready_mode = rmode;
        for (int p = 0; p < n; p++) begin
            for (int f = 0; f < NF; f++) begin
                tap_q.push_back('{f: f, p: p});
            end
        end
        exp_n     = n;
        res_seen  = 0;
        t_fin     = -1;
        r_fin     = -1;
        exp_stall = 0;
        acc_cyc   = cyc + 1;
        exp_done  = (n == 0) ? cyc + 1 : -1;
        model_on  = 1'b1;
        num_pixels = 16'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        num_pixels = 16'($urandom);
    endtask

    task automatic finish_tile(input int budget, input bit poke);
        for (int i = 0; i < budget && model_on; i++) begin
            // A start while busy must be ignored.
            if (poke && i == 3 && model_on && cyc >= acc_cyc && exp_done < 0) begin
                start = 1'b1;
                num_pixels = 16'($urandom_range(0, 5));
            end
            step();
            start = 1'b0;
        end
        if (model_on) begin
            vectors++;
            miscompares++;
            $display("FAIL tile_timeout: tile still open, expected done within %0d cycles", budget);
            clear_model();
        end
    endtask

    task automatic run_tile(input int n, input int rmode, input bit poke);
        start_tile(n, rmode);
        finish_tile(n * NF * 4 + 60, poke);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tap_valid"}, tap_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_filt_idx"}, filt_idx, 0);
        check({tag, "_pix_idx"}, pix_idx, 0);
        check({tag, "_acc_clear"}, acc_clear, 1'b0);
        check({tag, "_acc_last"}, acc_last, 1'b0);
    endtask

    initial begin : driver
        bit found;
        #2;
        check_idle_outputs("reset");
`ifdef PERF_COUNT_EN
        check("reset_perf", perf_stall_cnt, 0);
`endif
        step();
        reset = 1'b1;
        step();

        // Two pixels, always ready, results 2 cycles after each last tap.
        res_delay = 2;
        run_tile(2, 0, 1'b0);
        // One pixel with ready toggling.
        res_delay = -1;
        run_tile(1, 1, 1'b0);
        // Empty tile: done without any busy or tap.
        run_tile(0, 0, 1'b0);

        // Results while idle are ignored; abort beats a simultaneous start.
        spur = 1'b1;
        repeat (4) step();
        spur = 1'b0;
        num_pixels = 16'd3;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) step();

        // Abort in the middle of pixel 1.
        start_tile(3, 2);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (tap_valid && pix_idx == 16'd1 && filt_idx == 4'd4) found = 1'b1;
        end
        check("abort_point_reached", found, 1'b1);
        #1;
        abort = 1'b1;
        tap_ready = 1'b0;
        clear_model();
        step();
        abort = 1'b0;
        check_idle_outputs("abort");
        repeat (3) step();
        run_tile(3, 0, 1'b0);

        // Reset asserted mid-run.
        start_tile(4, 2);
        repeat (10) step();
        reset = 1'b0;
        clear_model();
        #1;
        check_idle_outputs("midreset");
`ifdef PERF_COUNT_EN
        check("midreset_perf", perf_stall_cnt, 0);
`endif
        step();
        reset = 1'b1;
        step();
        run_tile(2, 2, 1'b0);

        // Exactly five stalled RUN cycles.
        stall_left = 5;
        run_tile(1, 3, 1'b0);

        // Randomised tiles, some with a start pulse while busy.
        for (int k = 0; k < 20; k++) begin
            run_tile($urandom_range(0, 6), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
